reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_arb_pkg.sv | 14 +
 rtl/reg_bank_arbiter_rr_pick.sv | 29 ++
 rtl/reg_bank_arbiter.sv | 90 +++++++++
 tb/tb_reg_bank_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arb_pkg.sv
// Shared types and default sizing for the register-bank write arbiter.
package reg_bank_arb_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WRITE,
    CHECK
  } state_t;

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import reg_bank_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter serialising requester writes into a shared register bank,
// with a readback check after every write.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_REQ = DEFAULT_N_REQ
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic                   bank_wr_en,
  output logic [WIDTH-1:0]       bank_in,
  input  logic [WIDTH-1:0]       bank_out
);

  localparam int IW = $clog2(N_REQ);

  state_t           state, state_next;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win_q;
  logic [IW-1:0]    pick;
  logic             pick_valid;
  logic [WIDTH-1:0] data_q;

  rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .winner(pick),
    .valid (pick_valid)
  );

  // Winner, its data and the rotated pointer are captured together on leaving IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      win_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_valid) begin
        win_q  <= pick;
        data_q <= req_data[pick*WIDTH +: WIDTH];
        ptr    <= (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    gnt        = '0;
    done       = '0;
    err        = 1'b0;
    bank_wr_en = 1'b0;
    bank_in    = '0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = GRANT;
      end
      GRANT: begin
        gnt[win_q] = 1'b1;
        bank_in    = data_q;
        state_next = WRITE;
      end
      WRITE: begin
        gnt[win_q] = 1'b1;
        bank_wr_en = 1'b1;
        bank_in    = data_q;
        state_next = CHECK;
      end
      CHECK: begin
        gnt[win_q]  = 1'b1;
        done[win_q] = 1'b1;
        err         = (bank_out != data_q);
        bank_in     = data_q;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench: arbiter driving a behavioural register bank, compared
// against a transaction-level round-robin model.
module tb_reg_bank_arbiter;
  import reg_bank_arb_pkg::*;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] req_data = '0;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   err;
  logic                   bank_wr_en;
  logic [WIDTH-1:0]       bank_in;
  logic [WIDTH-1:0]       bank_out;

  logic [WIDTH-1:0]       bank_q;
  logic                   bank_ignore = 1'b0;

  int                     nChecks = 0;
  int                     nPassed = 0;

  // Transaction model: phase counts cycles since the grant edge, 0 = idle
  int                     m_phase = 0;
  int                     m_ptr = 0;
  int                     m_win = 0;
  logic [WIDTH-1:0]       m_data = '0;
  logic [WIDTH-1:0]       m_bank = '0;

  reg_bank_arbiter #(
    .WIDTH(WIDTH),
    .N_REQ(N_REQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .bank_wr_en(bank_wr_en),
    .bank_in   (bank_in),
    .bank_out  (bank_out)
  );

  always #5 clk = ~clk;

  // Register bank shares the controller's reset; bank_ignore models a stuck write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bank_q <= '0;
    else if (bank_wr_en && !bank_ignore) bank_q <= bank_in;
  end
  assign bank_out = bank_q;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkAll();
    logic [N_REQ-1:0] oneHot;
    oneHot = N_REQ'(1) << m_win;
    checkOutput("gnt", 32'(gnt), (m_phase != 0) ? 32'(oneHot) : 32'd0);
    checkOutput("wr_en", 32'(bank_wr_en), (m_phase == 2) ? 32'd1 : 32'd0);
    checkOutput("done", 32'(done), (m_phase == 3) ? 32'(oneHot) : 32'd0);
    checkOutput("err", 32'(err), (m_phase == 3 && m_bank != m_data) ? 32'd1 : 32'd0);
    checkOutput("bank_in", 32'(bank_in), (m_phase != 0) ? 32'(m_data) : 32'd0);
    checkOutput("bank_out", 32'(bank_out), 32'(m_bank));
  endtask

  task automatic modelReset();
    m_phase = 0;
    m_ptr   = 0;
    m_win   = 0;
    m_data  = '0;
    m_bank  = '0;
  endtask

  // Called at a falling edge: checks this cycle, drives the next, advances the model
  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ*WIDTH-1:0] d);
    bit found;
    checkAll();
    req      = r;
    req_data = d;
    if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && r[(m_ptr + k) % N_REQ]) begin
          found = 1'b1;
          m_win = (m_ptr + k) % N_REQ;
        end
      end
      if (found) begin
        m_data  = d[m_win*WIDTH +: WIDTH];
        m_ptr   = (m_win + 1) % N_REQ;
        m_phase = 1;
      end
    end else begin
      if (m_phase == 2 && !bank_ignore) m_bank = m_data;
      m_phase = (m_phase + 1) % 4;
    end
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, $urandom);
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    checkAll();
    rst = 1'b1;
  endtask

  initial begin
    logic [N_REQ-1:0] r;
    modelReset();
    @(negedge clk);
    checkAll();
    rst = 1'b1;

    // Single request from requester 0
    applyStimulus(4'b0001, 32'h0000_0004);
    idleCycles(4);
    checkOutput("single_bank", 32'(bank_q), 32'h04);

    // All requesters contending, five rounds
    for (int i = 0; i < 20; i++) applyStimulus(4'b1111, 32'h1312_1110);
    idleCycles(2);

    // Move pointer to 2, then only 0 and 1 request
    applyStimulus(4'b0010, 32'h0000_2200);
    idleCycles(3);
    for (int i = 0; i < 8; i++) applyStimulus(4'b0011, 32'h0000_3130);
    idleCycles(2);

    // One-cycle request pulse, data changes right after sampling
    applyStimulus(4'b0010, 32'h0000_0600);
    for (int i = 0; i < 4; i++) applyStimulus('0, 32'hFFFF_FFFF);
    checkOutput("hold_bank", 32'(bank_q), 32'h06);

    // Readback mismatch against a bank that drops the write
    doReset();
    bank_ignore = 1'b1;
    applyStimulus(4'b0001, 32'h0000_00AA);
    idleCycles(4);
    bank_ignore = 1'b0;

    // Reset while the transaction is in WRITE
    applyStimulus(4'b0001, 32'h0000_0055);
    applyStimulus('0, 32'h0000_0055);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr_en", 32'(bank_wr_en), 32'd0);
    checkOutput("rst_bank_in", 32'(bank_in), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    modelReset();
    @(negedge clk);
    checkAll();
    rst = 1'b1;
    applyStimulus(4'b0100, 32'h0077_0000);
    checkOutput("post_rst_gnt", 32'(gnt), 32'h4);
    idleCycles(4);

    // Randomised traffic with occasional stuck-bank cycles
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 2) == 0) ? '0 : N_REQ'($urandom);
      bank_ignore = ($urandom_range(0, 15) == 0);
      applyStimulus(r, $urandom);
    end
    bank_ignore = 1'b0;
    idleCycles(4);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
